// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with double-buffered, tear-free display data.
// Optional leading-zero suppression is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl #(
  parameter int DIGITS     = 4,
  parameter int CLK_DIV    = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic [6:0]            seg7_7bit,
  output logic [DIGITS-1:0]     seg7_an,
  output logic                  seg7_dp,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PS_W  = $clog2(CLK_DIV);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [PS_W-1:0]   PS_MAX   = PS_W'(CLK_DIV - 1);
  localparam logic [6:0]        SEG_INV  = {7{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_INV   = {DIGITS{ACTIVE_LOW}};

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h3F;
      4'h1: code = 7'h06;
      4'h2: code = 7'h5B;
      4'h3: code = 7'h4F;
      4'h4: code = 7'h66;
      4'h5: code = 7'h6D;
      4'h6: code = 7'h7D;
      4'h7: code = 7'h07;
      4'h8: code = 7'h7F;
      4'h9: code = 7'h6F;
      4'hA: code = 7'h77;
      4'hB: code = 7'h7C;
      4'hC: code = 7'h39;
      4'hD: code = 7'h5E;
      4'hE: code = 7'h79;
      4'hF: code = 7'h71;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

  logic [PS_W-1:0]     ps_r;
  logic [IDX_W-1:0]    idx_r;
  logic [4*DIGITS-1:0] stage_data_r;
  logic [DIGITS-1:0]   stage_dp_r;
  logic [DIGITS-1:0]   stage_blank_r;
  logic                pending_r;
  logic [4*DIGITS-1:0] shadow_data_r;
  logic [DIGITS-1:0]   shadow_dp_r;
  logic [DIGITS-1:0]   shadow_blank_r;
  logic [DIGITS-1:0]   dark_mask_s;
  logic                tick_s;
  logic                boundary_s;

  assign tick_s     = (ps_r == PS_MAX);
  assign boundary_s = tick_s && (idx_r == LAST_IDX);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Digit i>0 is suppressed when it and every higher nibble are zero.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] val);
    logic [DIGITS-1:0] mask;
    logic              all_zero;
    mask     = {DIGITS{1'b0}};
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      all_zero = all_zero && (val[4*i +: 4] == 4'h0);
      mask[i]  = all_zero;
    end
    return mask;
  endfunction

  logic [DIGITS-1:0] lz_mask_r;

  // Mask follows the value that becomes visible at each frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      lz_mask_r <= {DIGITS{1'b0}};
    end else if (boundary_s) begin
      lz_mask_r <= lz_mask(pending_r ? stage_data_r : shadow_data_r);
    end else begin
      lz_mask_r <= lz_mask_r;
    end
  end

  assign dark_mask_s = lz_mask_r;
`else
  assign dark_mask_s = {DIGITS{1'b0}};
`endif

  // Prescaler and digit index scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_r  <= {PS_W{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else if (tick_s) begin
      ps_r  <= {PS_W{1'b0}};
      idx_r <= (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
    end else begin
      ps_r  <= ps_r + PS_W'(1);
    end
  end

  // Staging capture on load; shadow takes the old staging at a boundary, so a coincident load waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_data_r   <= {(4*DIGITS){1'b0}};
      stage_dp_r     <= {DIGITS{1'b0}};
      stage_blank_r  <= {DIGITS{1'b0}};
      pending_r      <= 1'b0;
      shadow_data_r  <= {(4*DIGITS){1'b0}};
      shadow_dp_r    <= {DIGITS{1'b0}};
      shadow_blank_r <= {DIGITS{1'b0}};
    end else begin
      if (boundary_s && pending_r) begin
        shadow_data_r  <= stage_data_r;
        shadow_dp_r    <= stage_dp_r;
        shadow_blank_r <= stage_blank_r;
      end
      if (load) begin
        stage_data_r  <= data;
        stage_dp_r    <= dp_in;
        stage_blank_r <= blank;
        pending_r     <= 1'b1;
      end else if (boundary_s) begin
        pending_r     <= 1'b0;
      end
    end
  end

  logic [3:0]        cur_nib_s;
  logic              cur_dp_s;
  logic              cur_dark_s;
  logic [DIGITS-1:0] an_onehot_s;

  // Select the shadow fields of the digit currently being scanned.
  always_comb begin
    cur_nib_s   = 4'h0;
    cur_dp_s    = 1'b0;
    cur_dark_s  = 1'b0;
    an_onehot_s = {DIGITS{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_r == IDX_W'(i)) begin
        cur_nib_s      = shadow_data_r[4*i +: 4];
        cur_dp_s       = shadow_dp_r[i];
        cur_dark_s     = shadow_blank_r[i] | dark_mask_s[i];
        an_onehot_s[i] = 1'b1;
      end else begin
        an_onehot_s[i] = 1'b0;
      end
    end
  end

  // Registered, polarity-adjusted display outputs; a dark digit keeps its anode slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg7_an    <= AN_INV;
      seg7_7bit  <= SEG_INV;
      seg7_dp    <= ACTIVE_LOW;
      frame_done <= 1'b0;
    end else begin
      seg7_an    <= an_onehot_s ^ AN_INV;
      seg7_7bit  <= (cur_dark_s ? 7'h00 : hex7(cur_nib_s)) ^ SEG_INV;
      seg7_dp    <= (cur_dp_s && !cur_dark_s) ^ ACTIVE_LOW;
      frame_done <= boundary_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (DIGITS=4, CLK_DIV=4, ACTIVE_LOW=1); frames are checked slot by slot.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic [3:0]  blank = 4'b0000;
  logic        load = 1'b0;
  logic [6:0]  seg7_7bit;
  logic [3:0]  seg7_an;
  logic        seg7_dp;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [3:0] obs_an [16];
  logic [6:0] obs_seg[16];
  logic       obs_dp [16];
  logic       obs_fd [16];
  logic [3:0] exp_an [16];
  logic [6:0] exp_seg[16];
  logic       exp_dp [16];
  logic       exp_fd [16];

  seg7_scan_ctrl #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .blank(blank), .load(load),
    .seg7_7bit(seg7_7bit), .seg7_an(seg7_an), .seg7_dp(seg7_dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one 16-cycle frame starting right after a frame_done, with up to two loads at given slots.
  task automatic capture_frame(input int la, input logic [15:0] da, input int lb, input logic [15:0] db,
                               input logic [3:0] ldp, input logic [3:0] lbl);
    for (int n = 0; n < 16; n++) begin
      if (n == la) begin data = da; dp_in = ldp; blank = lbl; load = 1'b1; end
      if (n == lb) begin data = db; dp_in = ldp; blank = lbl; load = 1'b1; end
      step();
      load = 1'b0;
      obs_an[n] = seg7_an; obs_seg[n] = seg7_7bit; obs_dp[n] = seg7_dp; obs_fd[n] = frame_done;
    end
  endtask

  // Expected frame from hand-inverted segment codes for digits 3..0.
  task automatic build_exp(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                           input logic [6:0] s0, input logic [3:0] dpon, input logic [3:0] dark);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int n = 0; n < 16; n++) begin
      exp_an[n]  = ~(4'b0001 << (n / 4));
      exp_seg[n] = s[n / 4];
      exp_dp[n]  = !(dpon[n / 4] && !dark[n / 4]);
      exp_fd[n]  = (n == 15);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (seg7_an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b exp 1111", seg7_an); end
    checks++; if (seg7_7bit !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp 7f", seg7_7bit); end
    checks++; if (seg7_dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", seg7_dp); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", frame_done); end
  endtask

  task automatic test_scan_latch();
    int k;
    rst = 1'b0; data = 16'h12A0; load = 1'b1;
    step();
    load = 1'b0;
    checks++; if (seg7_an !== 4'b1110) begin errors++; $display("FAIL first_an got %b exp 1110", seg7_an); end
    checks++; if (seg7_7bit !== 7'h40) begin errors++; $display("FAIL first_seg got %h exp 40", seg7_7bit); end
    k = 0;
    while (frame_done !== 1'b1 && k < 40) begin step(); k++; end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL wait_frame_done got %b exp 1", frame_done); end
    capture_frame(-1, 16'h0000, -1, 16'h0000, 4'b0000, 4'b0000);
    build_exp(7'h79, 7'h24, 7'h08, 7'h40, 4'b0000, 4'b0000);
    for (int n = 0; n < 16; n++) begin
      checks++; if (obs_an[n] !== exp_an[n]) begin errors++; $display("FAIL scan_an n=%0d got %b exp %b", n, obs_an[n], exp_an[n]); end
      checks++; if (obs_seg[n] !== exp_seg[n]) begin errors++; $display("FAIL scan_seg n=%0d got %h exp %h", n, obs_seg[n], exp_seg[n]); end
      checks++; if (obs_dp[n] !== exp_dp[n]) begin errors++; $display("FAIL scan_dp n=%0d got %b exp %b", n, obs_dp[n], exp_dp[n]); end
      checks++; if (obs_fd[n] !== exp_fd[n]) begin errors++; $display("FAIL scan_fd n=%0d got %b exp %b", n, obs_fd[n], exp_fd[n]); end
    end
  endtask

  task automatic test_tear_free();
    capture_frame(6, 16'h1111, -1, 16'h0000, 4'b0000, 4'b0000);
    build_exp(7'h79, 7'h24, 7'h08, 7'h40, 4'b0000, 4'b0000);
    for (int n = 0; n < 16; n++) begin
      checks++; if (obs_seg[n] !== exp_seg[n]) begin errors++; $display("FAIL tear_old_seg n=%0d got %h exp %h", n, obs_seg[n], exp_seg[n]); end
    end
    capture_frame(-1, 16'h0000, -1, 16'h0000, 4'b0000, 4'b0000);
    build_exp(7'h79, 7'h79, 7'h79, 7'h79, 4'b0000, 4'b0000);
    for (int n = 0; n < 16; n++) begin
      checks++; if (obs_seg[n] !== exp_seg[n]) begin errors++; $display("FAIL tear_new_seg n=%0d got %h exp %h", n, obs_seg[n], exp_seg[n]); end
      checks++; if (obs_an[n] !== exp_an[n]) begin errors++; $display("FAIL tear_new_an n=%0d got %b exp %b", n, obs_an[n], exp_an[n]); end
    end
  endtask

  task automatic test_coincident_load();
    capture_frame(4, 16'h3210, 15, 16'hFFFF, 4'b0000, 4'b0000);
    build_exp(7'h79, 7'h79, 7'h79, 7'h79, 4'b0000, 4'b0000);
    for (int n = 0; n < 16; n++) begin
      checks++; if (obs_seg[n] !== exp_seg[n]) begin errors++; $display("FAIL coin_hold_seg n=%0d got %h exp %h", n, obs_seg[n], exp_seg[n]); end
      checks++; if (obs_fd[n] !== exp_fd[n]) begin errors++; $display("FAIL coin_hold_fd n=%0d got %b exp %b", n, obs_fd[n], exp_fd[n]); end
    end
    capture_frame(-1, 16'h0000, -1, 16'h0000, 4'b0000, 4'b0000);
    build_exp(7'h30, 7'h24, 7'h79, 7'h40, 4'b0000, 4'b0000);
    for (int n = 0; n < 16; n++) begin
      checks++; if (obs_seg[n] !== exp_seg[n]) begin errors++; $display("FAIL coin_old_seg n=%0d got %h exp %h", n, obs_seg[n], exp_seg[n]); end
    end
  endtask

  task automatic test_blank_dp();
    capture_frame(2, 16'h8421, -1, 16'h0000, 4'b0001, 4'b0100);
    build_exp(7'h0E, 7'h0E, 7'h0E, 7'h0E, 4'b0000, 4'b0000);
    for (int n = 0; n < 16; n++) begin
      checks++; if (obs_seg[n] !== exp_seg[n]) begin errors++; $display("FAIL coin_new_seg n=%0d got %h exp %h", n, obs_seg[n], exp_seg[n]); end
    end
    capture_frame(-1, 16'h0000, -1, 16'h0000, 4'b0000, 4'b0000);
    build_exp(7'h00, 7'h7F, 7'h24, 7'h79, 4'b0001, 4'b0100);
    for (int n = 0; n < 16; n++) begin
      checks++; if (obs_an[n] !== exp_an[n]) begin errors++; $display("FAIL blank_an n=%0d got %b exp %b", n, obs_an[n], exp_an[n]); end
      checks++; if (obs_seg[n] !== exp_seg[n]) begin errors++; $display("FAIL blank_seg n=%0d got %h exp %h", n, obs_seg[n], exp_seg[n]); end
      checks++; if (obs_dp[n] !== exp_dp[n]) begin errors++; $display("FAIL blank_dp n=%0d got %b exp %b", n, obs_dp[n], exp_dp[n]); end
    end
  endtask

  task automatic test_leading_zero();
    capture_frame(1, 16'h0050, -1, 16'h0000, 4'b0000, 4'b0000);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    build_exp(7'h7F, 7'h7F, 7'h12, 7'h40, 4'b0000, 4'b1100);
`else
    build_exp(7'h40, 7'h40, 7'h12, 7'h40, 4'b0000, 4'b0000);
`endif
    capture_frame(-1, 16'h0000, -1, 16'h0000, 4'b0000, 4'b0000);
    for (int n = 0; n < 16; n++) begin
      checks++; if (obs_seg[n] !== exp_seg[n]) begin errors++; $display("FAIL lz_seg n=%0d got %h exp %h", n, obs_seg[n], exp_seg[n]); end
      checks++; if (obs_an[n] !== exp_an[n]) begin errors++; $display("FAIL lz_an n=%0d got %b exp %b", n, obs_an[n], exp_an[n]); end
      checks++; if (obs_dp[n] !== exp_dp[n]) begin errors++; $display("FAIL lz_dp n=%0d got %b exp %b", n, obs_dp[n], exp_dp[n]); end
    end
  endtask

  task automatic test_reset_mid_digit();
    logic [3:0] an_exp;
    repeat (6) step();
    rst = 1'b1;
    step();
    checks++; if (seg7_an !== 4'b1111) begin errors++; $display("FAIL midrst_an got %b exp 1111", seg7_an); end
    checks++; if (seg7_7bit !== 7'h7F) begin errors++; $display("FAIL midrst_seg got %h exp 7f", seg7_7bit); end
    checks++; if (seg7_dp !== 1'b1) begin errors++; $display("FAIL midrst_dp got %b exp 1", seg7_dp); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst_fd got %b exp 0", frame_done); end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      an_exp = (k < 4) ? 4'b1110 : 4'b1101;
      checks++; if (seg7_an !== an_exp) begin errors++; $display("FAIL restart_an k=%0d got %b exp %b", k, seg7_an, an_exp); end
      checks++; if (seg7_7bit !== 7'h40) begin errors++; $display("FAIL restart_seg k=%0d got %h exp 40", k, seg7_7bit); end
    end
  endtask

  initial begin
    test_reset();
    test_scan_latch();
    test_tear_free();
    test_coincident_load();
    test_blank_dp();
    test_leading_zero();
    test_reset_mid_digit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
